// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared FSM encodings, port indices and RAM read/write convention
package ram_arbiter_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;
  localparam logic RW_READ = 1'b1;
  localparam logic RW_WRITE = 1'b0;
endpackage

// File: rtl/ram_arbiter_wait.sv
// wait_counter: loadable down-counter with zero flag; ports clk, rst, load, dec -> zero
module wait_counter #(
  parameter int WIDTH = 2,
  parameter int LOAD = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);
  logic [WIDTH-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= rst ? '0 : load ? WIDTH'(LOAD) : (dec && !zero) ? cnt - 1'b1 : cnt;
  assign zero = cnt == '0;
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin two-port sequencer for the register RAM; p0/p1 req/rw/addr/wdata in, rdata/ack out, ram_addr/ce/rw out, ram_data inout
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 8,
  parameter int WAIT_CYCLES = 3
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               p0_req,
  input  logic               p0_rw,
  input  logic [A_WIDTH-1:0] p0_addr,
  input  logic [D_WIDTH-1:0] p0_wdata,
  output logic [D_WIDTH-1:0] p0_rdata,
  output logic               p0_ack,
  input  logic               p1_req,
  input  logic               p1_rw,
  input  logic [A_WIDTH-1:0] p1_addr,
  input  logic [D_WIDTH-1:0] p1_wdata,
  output logic [D_WIDTH-1:0] p1_rdata,
  output logic               p1_ack,
  output logic [A_WIDTH-1:0] ram_addr,
  output logic               ram_ce,
  output logic               ram_rw,
  inout  wire  [D_WIDTH-1:0] ram_data
);
  localparam int CW = $clog2(WAIT_CYCLES);
  state_t state, state_nx;
  logic last, gnt, grant, any_req, cnt_zero, start, finish, oe;
  logic [D_WIDTH-1:0] wdata_q;
  assign any_req = p0_req | p1_req;
  // under contention the port not granted last wins; reset leaves last=PORT1
  assign grant = (p0_req && p1_req) ? ~last : (p1_req ? PORT1 : PORT0);
  assign start = state == S_IDLE && any_req;
  assign finish = state == S_ACCESS && cnt_zero;
  assign oe = ram_ce & ~ram_rw;
  wait_counter #(.WIDTH(CW), .LOAD(WAIT_CYCLES - 1)) u_wait (
    .clk(clk),
    .rst(clr),
    .load(start),
    .dec(state == S_ACCESS),
    .zero(cnt_zero)
  );
  always_ff @(posedge clk)
    state <= clr ? S_IDLE : state_nx;
  always_comb begin
    state_nx = state;
    state_nx = (state == S_IDLE) ? (any_req ? S_ACCESS : S_IDLE) :
               (state == S_ACCESS) ? (cnt_zero ? S_DONE : S_ACCESS) : S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      ram_ce <= 1'b0;
      ram_rw <= RW_READ;
      ram_addr <= '0;
      wdata_q <= '0;
      p0_ack <= 1'b0;
      p1_ack <= 1'b0;
      p0_rdata <= '0;
      p1_rdata <= '0;
      last <= PORT1;
      gnt <= PORT0;
    end else begin
      ram_ce <= state_nx == S_ACCESS;
      p0_ack <= finish && gnt == PORT0;
      p1_ack <= finish && gnt == PORT1;
      if (start) begin
        gnt <= grant;
        last <= grant;
        ram_addr <= grant ? p1_addr : p0_addr;
        ram_rw <= grant ? p1_rw : p0_rw;
        wdata_q <= grant ? p1_wdata : p0_wdata;
      end else if (state_nx != S_ACCESS) begin
        ram_rw <= RW_READ;
      end
      // RAM output register has been valid since the second ACCESS cycle
      if (finish && ram_rw == RW_READ && gnt == PORT0) p0_rdata <= ram_data;
      if (finish && ram_rw == RW_READ && gnt == PORT1) p1_rdata <= ram_data;
    end
  end
  for (genvar i = 0; i < D_WIDTH; i++) begin : g_drv
    bufif1 u_buf (ram_data[i], wdata_q[i], oe);
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed self-checking bench for ram_arbiter (WAIT_CYCLES=3 and 2 instances)
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;
  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_err = 0;
  logic p0_req = 0, p0_rw = 1, p1_req = 0, p1_rw = 1;
  logic [7:0] p0_addr = 0, p0_wdata = 0, p1_addr = 0, p1_wdata = 0;
  logic [7:0] p0_rdata, p1_rdata, a_addr;
  logic p0_ack, p1_ack, a_ce, a_rw;
  wire [7:0] a_data;
  logic b_req = 0;
  logic [7:0] b_addr = 0;
  logic [7:0] b_rdata, b_p1_rdata, b_ram_addr;
  logic b_ack, b_p1_ack, b_ce, b_rw;
  wire [7:0] b_data;
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] out_a, out_b;
  logic mon_en = 0;
  logic x_seen = 0;
  ram_arbiter #(.D_WIDTH(8), .A_WIDTH(8), .WAIT_CYCLES(3)) dut_a (
    .clk(clk), .clr(clr),
    .p0_req(p0_req), .p0_rw(p0_rw), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_rdata(p0_rdata), .p0_ack(p0_ack),
    .p1_req(p1_req), .p1_rw(p1_rw), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_rdata(p1_rdata), .p1_ack(p1_ack),
    .ram_addr(a_addr), .ram_ce(a_ce), .ram_rw(a_rw), .ram_data(a_data)
  );
  ram_arbiter #(.D_WIDTH(8), .A_WIDTH(8), .WAIT_CYCLES(2)) dut_b (
    .clk(clk), .clr(clr),
    .p0_req(b_req), .p0_rw(1'b1), .p0_addr(b_addr), .p0_wdata(8'h00), .p0_rdata(b_rdata), .p0_ack(b_ack),
    .p1_req(1'b0), .p1_rw(1'b1), .p1_addr(8'h00), .p1_wdata(8'h00), .p1_rdata(b_p1_rdata), .p1_ack(b_p1_ack),
    .ram_addr(b_ram_addr), .ram_ce(b_ce), .ram_rw(b_rw), .ram_data(b_data)
  );
  // register-based RAM models preloaded with mem[i] = i, output register drives the bus on reads
  always @(posedge clk) begin
    if (clr) for (int i = 0; i < 256; i++) mem_a[i] <= 8'(i);
    else if (a_ce && a_rw) out_a <= mem_a[a_addr];
    else if (a_ce) mem_a[a_addr] <= a_data;
  end
  always @(posedge clk) begin
    if (clr) for (int i = 0; i < 256; i++) mem_b[i] <= 8'(i);
    else if (b_ce && b_rw) out_b <= mem_b[b_ram_addr];
    else if (b_ce) mem_b[b_ram_addr] <= b_data;
  end
  assign a_data = (a_ce && a_rw) ? out_a : 8'bz;
  assign b_data = (b_ce && b_rw) ? out_b : 8'bz;
  always @(negedge clk)
    if (mon_en && a_ce && $isunknown(a_data)) x_seen <= 1'b1;
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    clr = 1'b1;
    tick(2);
    clr = 1'b0;
    n_cmp++; if (a_ce !== 1'b0) begin n_err++; $display("FAIL reset_ce: got %b exp 0", a_ce); end
    n_cmp++; if (a_rw !== 1'b1) begin n_err++; $display("FAIL reset_rw: got %b exp 1", a_rw); end
    n_cmp++; if (a_addr !== 8'h00) begin n_err++; $display("FAIL reset_addr: got %h exp 00", a_addr); end
    n_cmp++; if ({p0_ack, p1_ack} !== 2'b00) begin n_err++; $display("FAIL reset_ack: got %b exp 00", {p0_ack, p1_ack}); end
    n_cmp++; if ({p0_rdata, p1_rdata} !== 16'h0000) begin n_err++; $display("FAIL reset_rdata: got %h exp 0000", {p0_rdata, p1_rdata}); end
    n_cmp++; if (dut_a.state !== S_IDLE) begin n_err++; $display("FAIL reset_state: got %0d exp IDLE", dut_a.state); end
  endtask
  task automatic test_single_read;
    p0_addr = 8'h00; p0_rw = 1'b1; p0_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      n_cmp++; if (a_ce !== (k <= 3)) begin n_err++; $display("FAIL single_ce[%0d]: got %b exp %b", k, a_ce, k <= 3); end
      n_cmp++; if (p0_ack !== (k == 4)) begin n_err++; $display("FAIL single_ack[%0d]: got %b exp %b", k, p0_ack, k == 4); end
    end
    p0_req = 1'b0;
    n_cmp++; if (p0_rdata !== 8'h00) begin n_err++; $display("FAIL single_rdata: got %h exp 00", p0_rdata); end
    tick(1);
  endtask
  task automatic test_write_read;
    mon_en = 1'b1;
    p1_addr = 8'h3C; p1_wdata = 8'hA5; p1_rw = 1'b0; p1_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      if (k == 2) begin
        n_cmp++; if (a_data !== 8'hA5) begin n_err++; $display("FAIL write_bus: got %h exp a5", a_data); end
        n_cmp++; if ({a_ce, a_rw, a_addr} !== {2'b10, 8'h3C}) begin n_err++; $display("FAIL write_ctrl: got %b%b %h exp 10 3c", a_ce, a_rw, a_addr); end
      end
    end
    n_cmp++; if (p1_ack !== 1'b1) begin n_err++; $display("FAIL write_ack: got %b exp 1", p1_ack); end
    p1_req = 1'b0; p1_wdata = 8'h00;
    tick(1);
    p1_rw = 1'b1; p1_req = 1'b1;
    tick(4);
    n_cmp++; if (p1_ack !== 1'b1) begin n_err++; $display("FAIL read_ack: got %b exp 1", p1_ack); end
    n_cmp++; if (p1_rdata !== 8'hA5) begin n_err++; $display("FAIL read_rdata: got %h exp a5", p1_rdata); end
    p1_req = 1'b0;
    tick(1);
    mon_en = 1'b0;
    n_cmp++; if (x_seen !== 1'b0) begin n_err++; $display("FAIL bus_x: got %b exp 0", x_seen); end
  endtask
  task automatic test_contention;
    logic [1:0] exp_port [3];
    logic [7:0] exp_data [3];
    int got, waited;
    exp_port = '{2'd0, 2'd1, 2'd0};
    exp_data = '{8'h01, 8'h02, 8'h01};
    clr = 1'b1; tick(1); clr = 1'b0;
    p0_addr = 8'h01; p1_addr = 8'h02; p0_rw = 1'b1; p1_rw = 1'b1;
    p0_req = 1'b1; p1_req = 1'b1;
    for (int g = 0; g < 3; g++) begin
      got = 2; waited = 0;
      for (int t = 1; t <= 10 && got == 2; t++) begin
        tick(1);
        waited = t;
        if (p0_ack || p1_ack) got = p1_ack ? 1 : 0;
      end
      n_cmp++; if (got !== int'(exp_port[g])) begin n_err++; $display("FAIL cont_grant[%0d]: got port %0d exp %0d", g, got, exp_port[g]); end
      n_cmp++; if (waited !== (g == 0 ? 4 : 5)) begin n_err++; $display("FAIL cont_gap[%0d]: got %0d exp %0d", g, waited, g == 0 ? 4 : 5); end
      n_cmp++; if ((got == 1 ? p1_rdata : p0_rdata) !== exp_data[g]) begin n_err++; $display("FAIL cont_rdata[%0d]: got %h exp %h", g, got == 1 ? p1_rdata : p0_rdata, exp_data[g]); end
      if (got == 1) p1_req = 1'b0;
    end
    p0_req = 1'b0;
    tick(1);
  endtask
  task automatic test_back_to_back;
    logic [7:0] addrs [4];
    int waited;
    logic seen;
    addrs = '{8'h10, 8'h20, 8'h30, 8'h40};
    p0_rw = 1'b1; p0_addr = addrs[0]; p0_req = 1'b1;
    for (int r = 0; r < 4; r++) begin
      waited = 0; seen = 1'b0;
      for (int t = 1; t <= 10 && !seen; t++) begin
        tick(1);
        waited = t;
        seen = p0_ack;
      end
      n_cmp++; if (waited !== (r == 0 ? 4 : 5) || !seen) begin n_err++; $display("FAIL b2b_gap[%0d]: got %0d (ack %b) exp %0d", r, waited, seen, r == 0 ? 4 : 5); end
      n_cmp++; if (p0_rdata !== addrs[r]) begin n_err++; $display("FAIL b2b_rdata[%0d]: got %h exp %h", r, p0_rdata, addrs[r]); end
      if (r < 3) p0_addr = addrs[r + 1];
    end
    p0_req = 1'b0;
    tick(1);
  endtask
  task automatic test_reset_mid;
    logic ack_seen;
    p1_addr = 8'h10; p1_rw = 1'b1; p1_req = 1'b1;
    tick(2);
    n_cmp++; if (dut_a.state !== S_ACCESS || a_ce !== 1'b1) begin n_err++; $display("FAIL mid_pre: got state %0d ce %b exp ACCESS 1", dut_a.state, a_ce); end
    clr = 1'b1; p1_req = 1'b0;
    tick(1);
    ack_seen = p1_ack;
    n_cmp++; if (a_ce !== 1'b0) begin n_err++; $display("FAIL mid_ce: got %b exp 0", a_ce); end
    n_cmp++; if (p1_rdata !== 8'h00) begin n_err++; $display("FAIL mid_rdata: got %h exp 00", p1_rdata); end
    n_cmp++; if (dut_a.state !== S_IDLE) begin n_err++; $display("FAIL mid_state: got %0d exp IDLE", dut_a.state); end
    clr = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick(1);
      ack_seen = ack_seen | p1_ack;
    end
    n_cmp++; if (ack_seen !== 1'b0) begin n_err++; $display("FAIL mid_ack: got %b exp 0", ack_seen); end
  endtask
  task automatic test_wait2;
    b_addr = 8'h5A; b_req = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick(1);
      n_cmp++; if (b_ce !== (k <= 2)) begin n_err++; $display("FAIL w2_ce[%0d]: got %b exp %b", k, b_ce, k <= 2); end
      n_cmp++; if (b_ack !== (k == 3)) begin n_err++; $display("FAIL w2_ack[%0d]: got %b exp %b", k, b_ack, k == 3); end
    end
    b_req = 1'b0;
    n_cmp++; if (b_rdata !== 8'h5A) begin n_err++; $display("FAIL w2_rdata: got %h exp 5a", b_rdata); end
    tick(1);
  endtask
  initial begin
    test_reset;
    test_single_read;
    test_write_read;
    test_contention;
    test_back_to_back;
    test_reset_mid;
    test_wait2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
